trace_emitter: RTL

TRACE_EMITTER -- requirements
Module: trace_emitter

---
 rtl/trace_pkg.sv | 49 ++++
 rtl/trace_emitter_if.sv | 32 +++
 rtl/trace_fifo.sv | 65 ++++++
 rtl/trace_emitter.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Trace emitter shared types: retire record payload, widths, serializer state
// and the record-to-word mapping used by the serializer.
package trace_pkg;

   localparam int unsigned PC_W        = 36;
   localparam int unsigned INST_W      = 32;
   localparam int unsigned REG_W       = 5;
   localparam int unsigned VAL_W       = 36;
   localparam int unsigned SEQ_W       = 8;
   localparam int unsigned WORD_W      = 16;
   localparam int unsigned IDX_W       = 3;
   localparam int unsigned CNT_W       = 16;
   localparam int unsigned TRACE_WORDS = 8;
   localparam logic [3:0]  TRACE_SYNC  = 4'hA;

   // One retired-instruction record as stored in the FIFO and holding register.
   typedef struct packed {
      logic [PC_W-1:0]   pc;
      logic [INST_W-1:0] inst;
      logic              wb_en;
      logic [REG_W-1:0]  wb_reg;
      logic [VAL_W-1:0]  wb_value;
      logic [SEQ_W-1:0]  seq;
   } trace_rec_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } ser_state_e;

   // Select word idx of a record's serialized form.
   function automatic logic [WORD_W-1:0] trace_word(input trace_rec_t rec,
                                                    input logic [IDX_W-1:0] idx);
      logic [WORD_W-1:0] w;
      w = '0;
      case (idx)
         3'd0:    w = {TRACE_SYNC, 3'b000, rec.wb_en, 3'b000, rec.wb_reg};
         3'd1:    w = {rec.pc[35:32], rec.wb_value[35:32], rec.seq};
         3'd2:    w = rec.pc[31:16];
         3'd3:    w = rec.pc[15:0];
         3'd4:    w = rec.inst[31:16];
         3'd5:    w = rec.inst[15:0];
         3'd6:    w = rec.wb_value[31:16];
         default: w = rec.wb_value[15:0];
      endcase
      return w;
   endfunction

endpackage

// File: rtl/trace_emitter_if.sv
// Trace emitter bus: retire-side inputs, serialized output stream and
// drop status.
//   slave  : the emitter (consumes retire events, drives the word stream)
//   master : the environment (core retire port plus trace sink)
interface trace_emitter_if;
   import trace_pkg::*;

   logic              trace_en;
   logic              retire_valid;
   logic [PC_W-1:0]   retire_pc;
   logic [INST_W-1:0] retire_inst;
   logic              retire_wb_en;
   logic [REG_W-1:0]  retire_wb_reg;
   logic [VAL_W-1:0]  retire_wb_value;
   logic              out_valid;
   logic [WORD_W-1:0] out_word;
   logic              out_ready;
   logic              overflow;
   logic [CNT_W-1:0]  drop_count;

   modport slave (
      input  trace_en, retire_valid, retire_pc, retire_inst,
             retire_wb_en, retire_wb_reg, retire_wb_value, out_ready,
      output out_valid, out_word, overflow, drop_count
   );

   modport master (
      output trace_en, retire_valid, retire_pc, retire_inst,
             retire_wb_en, retire_wb_reg, retire_wb_value, out_ready,
      input  out_valid, out_word, overflow, drop_count
   );
endinterface

// File: rtl/trace_fifo.sv
// Record FIFO for the trace emitter.
//   clk, rst   : clock, async active-high reset
//   push/data  : write one record (ignored when full)
//   pop        : drop head record (ignored when empty)
//   head       : current head record
//   full/empty : occupancy flags from the registered count
module trace_fifo
   import trace_pkg::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  trace_rec_t push_data,
   input  logic       pop,
   output trace_rec_t head,
   output logic       full,
   output logic       empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          push_ok;
   logic          pop_ok;
   trace_rec_t    mem_q [DEPTH];

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign head    = mem_q[rd_ptr_q];

   // Pointer/count update; DEPTH is a power of two so pointers wrap naturally.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; validity is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/trace_emitter.sv
// Retire trace emitter: captures retired instructions as sequence-tagged
// records, buffers them in a FIFO and serializes each as eight 16-bit words
// over a valid/ready stream. Records arriving while the FIFO is full are
// dropped and counted.
//   clk, rst : clock, async active-high reset
//   bus      : trace_emitter_if.slave (retire inputs, out stream, drop status)
module trace_emitter
   import trace_pkg::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input  logic clk,
   input  logic rst,
   trace_emitter_if.slave bus
);

   ser_state_e        state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   trace_rec_t        hold_q, hold_d;
   logic              out_valid_q, out_valid_d;
   logic [WORD_W-1:0] out_word_q, out_word_d;
   logic [SEQ_W-1:0]  seq_q, seq_d;
   logic              overflow_q, overflow_d;
   logic [CNT_W-1:0]  drop_count_q, drop_count_d;

   logic              retire_fire_c;
   logic              fifo_push_c;
   logic              fifo_pop_c;
   logic              drop_c;
   logic              xfer_c;
   logic              fifo_full;
   logic              fifo_empty;
   trace_rec_t        rec_c;
   trace_rec_t        fifo_head;

   assign retire_fire_c = bus.trace_en & bus.retire_valid;
   // Full is the start-of-cycle flag, so a same-cycle pop never admits a push.
   assign fifo_push_c   = retire_fire_c & ~fifo_full;
   assign drop_c        = retire_fire_c & fifo_full;
   assign xfer_c        = out_valid_q & bus.out_ready;

   assign rec_c.pc       = bus.retire_pc;
   assign rec_c.inst     = bus.retire_inst;
   assign rec_c.wb_en    = bus.retire_wb_en;
   assign rec_c.wb_reg   = bus.retire_wb_reg;
   assign rec_c.wb_value = bus.retire_wb_value;
   assign rec_c.seq      = seq_q;

   trace_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push_c),
      .push_data (rec_c),
      .pop       (fifo_pop_c),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Sequence tag and drop accounting; seq advances even for dropped records.
   always_comb begin
      seq_d        = seq_q;
      overflow_d   = overflow_q;
      drop_count_d = drop_count_q;
      if (retire_fire_c) seq_d = seq_q + SEQ_W'(1);
      if (drop_c) begin
         overflow_d = 1'b1;
         if (drop_count_q != {CNT_W{1'b1}}) drop_count_d = drop_count_q + CNT_W'(1);
      end
   end

   // Serializer next state; out_word is precomputed so the output is a flop.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      hold_d      = hold_q;
      out_valid_d = out_valid_q;
      out_word_d  = out_word_q;
      fifo_pop_c  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            out_valid_d = 1'b0;
            out_word_d  = '0;
            if (!fifo_empty) begin
               fifo_pop_c  = 1'b1;
               hold_d      = fifo_head;
               idx_d       = '0;
               state_d     = ST_SEND;
               out_valid_d = 1'b1;
               out_word_d  = trace_word(fifo_head, IDX_W'(0));
            end
         end
         ST_SEND: begin
            if (xfer_c) begin
               if (idx_q == IDX_W'(TRACE_WORDS - 1)) begin
                  // Last word gone: chain straight into the next record if any.
                  if (!fifo_empty) begin
                     fifo_pop_c = 1'b1;
                     hold_d     = fifo_head;
                     idx_d      = '0;
                     out_word_d = trace_word(fifo_head, IDX_W'(0));
                  end else begin
                     state_d     = ST_IDLE;
                     idx_d       = '0;
                     out_valid_d = 1'b0;
                     out_word_d  = '0;
                  end
               end else begin
                  idx_d      = idx_q + IDX_W'(1);
                  out_word_d = trace_word(hold_q, idx_q + IDX_W'(1));
               end
            end
         end
         default: begin
            state_d     = ST_IDLE;
            idx_d       = '0;
            out_valid_d = 1'b0;
            out_word_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         idx_q        <= '0;
         hold_q       <= '0;
         out_valid_q  <= 1'b0;
         out_word_q   <= '0;
         seq_q        <= '0;
         overflow_q   <= 1'b0;
         drop_count_q <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         hold_q       <= hold_d;
         out_valid_q  <= out_valid_d;
         out_word_q   <= out_word_d;
         seq_q        <= seq_d;
         overflow_q   <= overflow_d;
         drop_count_q <= drop_count_d;
      end
   end

   assign bus.out_valid  = out_valid_q;
   assign bus.out_word   = out_word_q;
   assign bus.overflow   = overflow_q;
   assign bus.drop_count = drop_count_q;

endmodule
